// File: rtl/frame_hex_monitor_if.sv
// Received byte-stream beat bundle (data, valid, last, err) feeding the
// frame hex monitor. The producer uses the master modport and the monitor
// uses the slave modport.
interface frame_hex_monitor_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_err;

    modport master (output in_data, in_valid, in_last, in_err);
    modport slave  (input  in_data, in_valid, in_last, in_err);
endinterface

// File: rtl/frame_hex_monitor.sv
// Byte-stream tap for the 8-digit hex display.
// - Captures a 4-byte window at a programmable offset from each good frame.
// - Keeps good-frame, error-frame and last-length statistics.
// - Drives a registered, freezable display word selected by sel.
module frame_hex_monitor #(
    parameter int OFFSET_W = 11,
    parameter int MAX_LEN  = 1522
) (
    input  logic                clk,
    input  logic                rstn,
    frame_hex_monitor_if.slave  s_in,
    input  logic [OFFSET_W-1:0] offset,
    input  logic [1:0]          sel,
    input  logic                freeze,
    output logic [31:0]         disp_data,
    output logic                disp_update
);

    typedef enum logic {ST_IDLE, ST_IN_FRAME} state_t;

    localparam logic [16:0] MAX_LEN_L = 17'(MAX_LEN);

    state_t              r_state;
    state_t              w_state_next;
    logic [15:0]         r_byte_idx;
    logic [OFFSET_W-1:0] r_off;
    logic                r_err_flag;
    logic [31:0]         r_window;
    logic [31:0]         r_cap_word;
    logic [31:0]         r_frame_cnt;
    logic [31:0]         r_err_cnt;
    logic [15:0]         r_last_len;
    logic [31:0]         r_disp_data;
    logic                r_disp_update;

    logic                w_first;
    logic [15:0]         w_idx;
    logic [15:0]         w_idx_inc;
    logic [OFFSET_W-1:0] w_off;
    logic [16:0]         w_rel;
    logic                w_in_win;
    logic [31:0]         w_window_base;
    logic [31:0]         w_window_cur;
    logic [16:0]         w_len;
    logic                w_err_cur;
    logic                w_eof;
    logic                w_good;
    logic [31:0]         w_mux;

    // Index/offset of the beat currently on the bus; a beat seen in IDLE is byte 0
    // and uses the live offset, later beats use the offset latched at frame start.
    always_comb begin
        w_first       = (r_state == ST_IDLE);
        w_idx         = w_first ? 16'd0 : r_byte_idx;
        w_off         = w_first ? offset : r_off;
        w_idx_inc     = (w_idx == 16'hFFFF) ? w_idx : w_idx + 16'd1;
        w_rel         = 17'(w_idx) - 17'(w_off);
        w_in_win      = (17'(w_idx) >= 17'(w_off)) && (w_rel <= 17'd3);
        w_window_base = w_first ? 32'd0 : r_window;
        w_len         = 17'(w_idx) + 17'd1;
        w_err_cur     = (w_first ? 1'b0 : r_err_flag) | s_in.in_err | (w_len > MAX_LEN_L);
        w_eof         = s_in.in_valid & s_in.in_last;
        w_good        = w_eof & ~w_err_cur;
    end

    // Window byte lanes: slot 0 is the most significant byte.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_window_cur[31-8*gi -: 8] =
                (w_in_win && (w_rel[1:0] == 2'(gi))) ? s_in.in_data
                                                      : w_window_base[31-8*gi -: 8];
        end
    endgenerate

    // Next-state logic: a single-beat frame never leaves IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     if (s_in.in_valid && !s_in.in_last) w_state_next = ST_IN_FRAME;
            ST_IN_FRAME: if (w_eof)                           w_state_next = ST_IDLE;
            default:                                          w_state_next = ST_IDLE;
        endcase
    end

    // State register; reset mid-frame drops the frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Per-beat tracking: byte index, latched offset, sticky error and window.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_byte_idx <= 16'd0;
            r_off      <= '0;
            r_err_flag <= 1'b0;
            r_window   <= 32'd0;
        end else if (s_in.in_valid) begin
            r_byte_idx <= w_idx_inc;
            r_window   <= w_window_cur;
            r_err_flag <= w_err_cur;
            if (w_first) r_off <= offset;
        end
    end

    // End-of-frame bookkeeping: capture and count good frames, count bad ones.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cap_word    <= 32'd0;
            r_last_len    <= 16'd0;
            r_frame_cnt   <= 32'd0;
            r_err_cnt     <= 32'd0;
            r_disp_update <= 1'b0;
        end else begin
            r_disp_update <= w_good;
            if (w_good) begin
                r_cap_word <= w_window_cur;
                r_last_len <= w_len[15:0];
                if (r_frame_cnt != 32'hFFFF_FFFF) r_frame_cnt <= r_frame_cnt + 32'd1;
            end else if (w_eof) begin
                if (r_err_cnt != 32'hFFFF_FFFF) r_err_cnt <= r_err_cnt + 32'd1;
            end
        end
    end

    // Display source selection.
    always_comb begin
        w_mux = r_cap_word;
        case (sel)
            2'd0: w_mux = r_cap_word;
            2'd1: w_mux = r_frame_cnt;
            2'd2: w_mux = {16'h0, r_last_len};
            2'd3: w_mux = r_err_cnt;
            default: w_mux = r_cap_word;
        endcase
    end

    // Registered display word; freeze holds it while statistics keep running.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        r_disp_data <= 32'd0;
        else if (!freeze) r_disp_data <= w_mux;
    end

    assign disp_data   = r_disp_data;
    assign disp_update = r_disp_update;

endmodule

// File: doc/frame_hex_monitor.md
Name: frame_hex_monitor

Overview:
Byte-stream tap that sits directly upstream of the 8-digit hex display driver and produces its 32-bit `disp_data` word. It watches the received Ethernet byte stream (valid/last/err beats) and captures a 4-byte window at a programmable offset from each good frame. It also keeps frame, length and error statistics. A 2-bit selector chooses which value drives the display, and a freeze input holds the shown value for reading.

Parameters:
OFFSET_W, 11, width of the byte-offset input (window start 0..2^OFFSET_W-1)
MAX_LEN, 1522, frames longer than this many bytes are counted as errors

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
in_data  input  8  stream byte, first byte of frame first
in_valid  input  1  beat qualifier; in_data/in_last/in_err are ignored when low
in_last  input  1  final beat of frame (qualified by in_valid)
in_err  input  1  beat carries error (FCS/PHY), qualified by in_valid
offset  input  OFFSET_W  byte index of window start
sel  input  2  display source select
freeze  input  1  hold disp_data
disp_data  output  32  word to display driver, first captured byte in [31:24]
disp_update  output  1  one-cycle pulse when a new good frame was captured

Behaviour:
- Reset (async, rstn=0): state=IDLE. byte_idx, window, cap_word, frame_cnt, err_cnt, last_len, disp_data all 0. disp_update=0. Reset mid-frame discards the frame; the next frame starts from IDLE.
- States:
  - IDLE: waits for in_valid. The first valid beat is byte 0 of a frame: it samples offset into off_r, clears the err_flag and window, and sets byte_idx=1. If in_last is also high (1-byte frame), the end-of-frame action happens the same cycle and the state stays IDLE. Otherwise go to IN_FRAME.
  - IN_FRAME: each valid beat increments byte_idx, saturating at 2^16-1. On in_last, do the end-of-frame action and return to IDLE.
- Window capture: a beat with index i, where off_r <= i <= off_r+3, writes byte slot (i-off_r). Slot 0 is [31:24] and slot 3 is [7:0]. Slots never reached stay 0x00, so a short frame yields zero padding.
- err_flag sets on any valid beat with in_err=1. It also sets when byte_idx exceeds MAX_LEN. It is sticky until the next frame starts.
- End-of-frame action (on the last beat; len = index of last beat + 1, including that beat):
  - Good frame (err_flag=0 and this beat's in_err=0 and len<=MAX_LEN): cap_word<=window including the current beat's byte; last_len<=len; frame_cnt++; disp_update pulses high next cycle.
  - Otherwise: err_cnt++; cap_word, last_len and frame_cnt are unchanged; no pulse.
- frame_cnt and err_cnt are 32-bit and saturate at 0xFFFFFFFF (no wrap).
- Display mux, registered with 1-cycle latency. If freeze=0, disp_data is:
  - sel=0: cap_word
  - sel=1: frame_cnt
  - sel=2: {16'h0, last_len}
  - sel=3: err_cnt
- If freeze=1, disp_data holds. Internal capture and counting continue while frozen.
- Changing sel affects disp_data on the next clock edge.
- in_valid=0 beats never change state or counters. Gaps inside a frame are legal.
- An offset change mid-frame has no effect until the next frame.

Test Plan:
- Reset, then send a 64-byte good frame with byte k = k and offset=6, sel=0 → disp_data=0x06070809 one cycle after the last beat. disp_update pulses once. frame_cnt=1.
- Send a 2-byte frame (0xAA, 0xBB) with offset=1, sel=0 → disp_data=0xBB000000 (zero padding). Then sel=2 → 0x00000002.
- Send a frame with in_err=1 on byte 10, then sel=3 → err_cnt=1. cap_word and frame_cnt are unchanged. No disp_update pulse.
- Send a 1600-byte frame with MAX_LEN=1522 → counted as error. Then send a 1-beat frame (valid & last together, data 0x5A, offset=0) → cap_word=0x5A000000, last_len=1.
- Set freeze=1 with sel=1, then send 3 good frames → disp_data is constant. Release freeze → disp_data shows the count incremented by 3 on the next cycle.
- Assert rstn low mid-frame at byte 20 → all outputs are 0 immediately. Then send a new 8-byte frame with offset=0 → disp_data = first 4 bytes of the new frame and frame_cnt=1.
